encap_output_streamer: RTL and testbench
========================================

Name: encap_output_streamer

Overview:
- Downstream stage of the encapsulation sequencer (encap_seq_gen).
- On start, which is normally tied to the sequencer's done, it reads the finished ciphertext and session key through the sequencer's read ports: C0 (syndrome), then C1 (confirmation hash), then K (session key).
- It emits them as one ordered 32-bit valid/ready stream for a host or UART bridge, with a segment tag and a last flag.
- Read-latency is absorbed with a 2-entry buffer, so backpressure never drops or duplicates words.

Parameters:
- parameter_set, 1, selects mceliece348864 (1) through 8192128 (5).
- m, 12 for set 1 else 13, field degree.
- t, 64/96/128/119/128 for sets 1..5, error weight.
- l, m*t, syndrome bit length.
- C0_WORDS, (l+31)/32, C0 word count; 24/39/52/49/52 for sets 1..5.
- C1_WORDS, 8, C1 word count.
- K_WORDS, 8, K word count.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a readout
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after the final word handshake
- rd_C0  out  1  C0 read strobe
- C0_addr  out  clog2(C0_WORDS)  C0 word address
- C0_out  in  32  C0 read data, valid 1 cycle after rd_C0
- rd_C1  out  1  C1 read strobe
- C1_addr  out  3  C1 word address
- C1_out  in  32  C1 read data, 1-cycle latency
- rd_K  out  1  K read strobe
- K_addr  out  3  K word address
- K_out  in  32  K read data, 1-cycle latency
- dout  out  32  stream data
- dout_valid  out  1  stream valid
- dout_ready  in  1  stream ready from consumer
- dout_seg  out  2  segment of the current word: 0=C0, 1=C1, 2=K
- dout_last  out  1  high with the final K word only

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs go to 0, including addresses, strobes, dout, dout_seg and the buffer contents.
  - Buffer count and in-flight flag clear.
  - Reset mid-readout abandons the transfer; no done pulse is produced.
- FSM states: IDLE, RD_C0, RD_C1, RD_K, DRAIN.
  - IDLE: start=1 → RD_C0. Address counter=0, busy=1 on the next cycle.
  - RD_C0: issue reads for addresses 0..C0_WORDS-1, then → RD_C1 with the counter cleared.
  - RD_C1: issue reads for addresses 0..7, then → RD_K.
  - RD_K: issue reads for addresses 0..7, then → DRAIN.
  - DRAIN: wait for the buffer to empty and the last word to be accepted, then → IDLE. done=1 for one cycle and busy=0 in that same cycle.
- Read issue rule:
  - A read is issued in a cycle only if (buffer count + in-flight + 1) ≤ 2, after accounting for a pop in the same cycle.
  - At most one rd_* is high per cycle, and only in the matching state.
  - The address is held stable while rd_* is high.
  - The address advances only on an issued read.
- Capture rule:
  - The cycle after a read, *_out is written into the buffer together with its segment tag.
  - The last-K marker is set for K address 7.
- Output rule:
  - dout/dout_seg/dout_last come from the buffer head; dout_valid = (count ≠ 0).
  - A word transfers on dout_valid & dout_ready.
  - dout holds stable while valid and not ready.
  - Simultaneous push and pop leaves the count unchanged.
- Word order on the stream: C0[0..C0_WORDS-1], C1[0..7], K[0..7].
  - Total = C0_WORDS+16 words; 40 for set 1.
  - For set 4 the final C0 word is passed verbatim, including its unused upper bits.
- Throughput: with dout_ready held at 1, the first dout_valid occurs 2 cycles after start and one word transfers every cycle thereafter.
- start while busy=1 is ignored.
- start in the same cycle as a done pulse is ignored.
- dout_ready=0 indefinitely: reads stop with 2 words buffered and nothing in flight; the state is held without loss.

Test Plan:
- Set 1, memories preloaded with C0[i]=0xC0000000+i, C1[i]=0xC1000000+i, K[i]=0x4B000000+i, ready=1, start pulse:
  - Expect 40 words in that exact order.
  - Expect dout_seg 0×24, 1×8, 2×8.
  - Expect dout_last only on 0x4B000007.
  - Expect done exactly 1 cycle after the final handshake.
  - Expect first valid at start+2.
- Random dout_ready (50%), same data: identical 40-word sequence, no duplicates or gaps, dout stable whenever valid & !ready.
- dout_ready=0 for 20 cycles after start:
  - Exactly 2 reads issued.
  - dout_valid=1 with dout=0xC0000000 held.
  - Releasing ready resumes at 0xC0000001 next.
- Second start pulse at word 10, and start coincident with done: both ignored, stream unchanged, single done pulse.
- rst asserted low at word 30 then released:
  - All outputs 0 immediately (asynchronous).
  - No done.
  - A new start then reproduces the full sequence from C0[0].
- Set 4 (C0_WORDS=49):
  - 65 words total.
  - C0_addr reaches 48, then C1_addr starts at 0.
  - dout_last on the 65th word.

Source files
------------

// File: rtl/encap_output_streamer.sv
// encap_output_streamer: reads C0, C1 and K from the encapsulation sequencer
// and streams them as one ordered 32-bit valid/ready stream with segment tag
// and last flag. A 2-entry buffer absorbs the 1-cycle read latency.
//
// state | meaning
// IDLE  | waiting for start
// RD_C0 | issuing syndrome reads, addresses 0..C0_WORDS-1
// RD_C1 | issuing confirmation hash reads, addresses 0..7
// RD_K  | issuing session key reads, addresses 0..7
// DRAIN | all reads issued, waiting for the last K word to be accepted
module encap_output_streamer #(
    parameter int parameter_set = 1,
    localparam int M = (parameter_set == 1) ? 12 : 13,
    localparam int T = (parameter_set == 1) ? 64 :
                       (parameter_set == 2) ? 96 :
                       (parameter_set == 4) ? 119 : 128,
    localparam int L = M * T,
    localparam int C0_WORDS = (L + 31) / 32,
    localparam int C0_AW = $clog2(C0_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_C0,
    output logic [C0_AW-1:0] C0_addr,
    input  logic [31:0]      C0_out,
    output logic             rd_C1,
    output logic [2:0]       C1_addr,
    input  logic [31:0]      C1_out,
    output logic             rd_K,
    output logic [2:0]       K_addr,
    input  logic [31:0]      K_out,
    output logic [31:0]      dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [1:0]       dout_seg,
    output logic             dout_last
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_C0 = 3'd1,
        RD_C1 = 3'd2,
        RD_K  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [C0_AW-1:0]   cnt_q, cnt_d;
    logic               inflight_q, inflight_d;
    logic [1:0]         inf_seg_q, inf_seg_d;
    logic               inf_last_q, inf_last_d;
    logic               done_q, done_d;
    logic [31:0]        buf_data_q [2];
    logic [31:0]        buf_data_d [2];
    logic [1:0]         buf_seg_q [2];
    logic [1:0]         buf_seg_d [2];
    logic [1:0]         buf_last_q, buf_last_d;
    logic               head_q, head_d;
    logic [1:0]         count_q, count_d;

    logic               pop;
    logic               rd_en;
    logic               seg_end;
    logic [2:0]         occ;
    logic               wr_idx;
    logic [31:0]        cap_data;

    // FSM, read issue and 2-entry buffer bookkeeping
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        inf_seg_d  = inf_seg_q;
        inf_last_d = 1'b0;
        buf_data_d = buf_data_q;
        buf_seg_d  = buf_seg_q;
        buf_last_d = buf_last_q;

        pop = (count_q != 2'd0) && dout_ready;
        // occupancy after this cycle's pop, not counting the read we may issue
        occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en = (occ <= 3'd1) &&
                ((state_q == RD_C0) || (state_q == RD_C1) || (state_q == RD_K));
        seg_end = (state_q == RD_C0) ? (cnt_q == C0_AW'(C0_WORDS - 1))
                                     : (cnt_q == C0_AW'(7));
        inflight_d = rd_en;

        case (state_q)
            IDLE: begin
                // a start coinciding with the done pulse belongs to the old run
                if (start && !done_q) begin
                    state_d = RD_C0;
                    cnt_d   = '0;
                end
            end
            RD_C0, RD_C1, RD_K: begin
                if (rd_en) begin
                    inf_seg_d  = (state_q == RD_C0) ? 2'd0 :
                                 (state_q == RD_C1) ? 2'd1 : 2'd2;
                    inf_last_d = (state_q == RD_K) && seg_end;
                    if (seg_end) begin
                        cnt_d   = '0;
                        state_d = (state_q == RD_C0) ? RD_C1 :
                                  (state_q == RD_C1) ? RD_K : DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pop && buf_last_q[head_q]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        case (inf_seg_q)
            2'd0:    cap_data = C0_out;
            2'd1:    cap_data = C1_out;
            default: cap_data = K_out;
        endcase

        // read data lands one cycle after the strobe; write behind the head
        wr_idx = head_q ^ count_q[0];
        if (inflight_q) begin
            buf_data_d[wr_idx] = cap_data;
            buf_seg_d[wr_idx]  = inf_seg_q;
            buf_last_d[wr_idx] = inf_last_q;
        end
        head_d  = pop ? ~head_q : head_q;
        count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            inf_seg_q  <= 2'd0;
            inf_last_q <= 1'b0;
            done_q     <= 1'b0;
            buf_data_q <= '{default: '0};
            buf_seg_q  <= '{default: '0};
            buf_last_q <= 2'b00;
            head_q     <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            inf_seg_q  <= inf_seg_d;
            inf_last_q <= inf_last_d;
            done_q     <= done_d;
            buf_data_q <= buf_data_d;
            buf_seg_q  <= buf_seg_d;
            buf_last_q <= buf_last_d;
            head_q     <= head_d;
            count_q    <= count_d;
        end
    end

    // read ports and stream outputs
    always_comb begin
        rd_C0      = rd_en && (state_q == RD_C0);
        rd_C1      = rd_en && (state_q == RD_C1);
        rd_K       = rd_en && (state_q == RD_K);
        C0_addr    = (state_q == RD_C0) ? cnt_q : '0;
        C1_addr    = (state_q == RD_C1) ? cnt_q[2:0] : 3'd0;
        K_addr     = (state_q == RD_K) ? cnt_q[2:0] : 3'd0;
        dout       = buf_data_q[head_q];
        dout_seg   = buf_seg_q[head_q];
        dout_last  = buf_last_q[head_q];
        dout_valid = (count_q != 2'd0);
        busy       = (state_q != IDLE);
        done       = done_q;
    end

endmodule

// File: tb/tb_encap_output_streamer.sv
// Scoreboard bench for encap_output_streamer: a set-1 instance exercised under
// several ready patterns, start misuse and mid-run reset, plus a set-4 instance.
module tb_encap_output_streamer;

    logic        clk;
    logic        rst;
    logic        start, dout_ready;
    logic        busy, done, rd_C0, rd_C1, rd_K, dout_valid, dout_last;
    logic [4:0]  C0_addr;
    logic [2:0]  C1_addr, K_addr;
    logic [31:0] C0_out, C1_out, K_out, dout;
    logic [1:0]  dout_seg;

    logic        start_4, ready_4;
    logic        busy_4, done_4, rd_C0_4, rd_C1_4, rd_K_4, valid_4, last_4;
    logic [5:0]  C0_addr_4;
    logic [2:0]  C1_addr_4, K_addr_4;
    logic [31:0] C0_out_4, C1_out_4, K_out_4, dout_4;
    logic [1:0]  seg_4;

    int n_vec = 0;
    int n_err = 0;
    int n_pop1 = 0, n_pop4 = 0;
    int done_cnt1 = 0, done_cnt4 = 0;
    int rd_cnt1 = 0;
    int mode = 0;
    logic [34:0] q1[$];
    logic [34:0] q4[$];
    logic        done_exp1 = 0, done_exp4 = 0;
    logic        prev_stall1 = 0;
    logic [34:0] prev_word1;
    logic [5:0]  last_c0_4 = 0, c0_at_switch_4 = 0;
    logic [2:0]  first_c1_4 = 3'd7;
    logic        seen_c1_4 = 0;

    encap_output_streamer #(.parameter_set(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_C0(rd_C0), .C0_addr(C0_addr), .C0_out(C0_out),
        .rd_C1(rd_C1), .C1_addr(C1_addr), .C1_out(C1_out),
        .rd_K(rd_K), .K_addr(K_addr), .K_out(K_out),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_seg(dout_seg), .dout_last(dout_last)
    );

    encap_output_streamer #(.parameter_set(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_4), .busy(busy_4), .done(done_4),
        .rd_C0(rd_C0_4), .C0_addr(C0_addr_4), .C0_out(C0_out_4),
        .rd_C1(rd_C1_4), .C1_addr(C1_addr_4), .C1_out(C1_out_4),
        .rd_K(rd_K_4), .K_addr(K_addr_4), .K_out(K_out_4),
        .dout(dout_4), .dout_valid(valid_4), .dout_ready(ready_4),
        .dout_seg(seg_4), .dout_last(last_4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // sequencer read ports: data is base pattern plus word address, 1-cycle latency
    always @(posedge clk) begin
        if (rd_C0)   C0_out   <= 32'hC000_0000 + 32'(C0_addr);
        if (rd_C1)   C1_out   <= 32'hC100_0000 + 32'(C1_addr);
        if (rd_K)    K_out    <= 32'h4B00_0000 + 32'(K_addr);
        if (rd_C0_4) C0_out_4 <= 32'hC000_0000 + 32'(C0_addr_4);
        if (rd_C1_4) C1_out_4 <= 32'hC100_0000 + 32'(C1_addr_4);
        if (rd_K_4)  K_out_4  <= 32'h4B00_0000 + 32'(K_addr_4);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // reference model: the expected stream is C0 words, then 8 C1, then 8 K
    function automatic logic [34:0] ent(input int seg, input int idx, input bit last);
        logic [31:0] base;
        base = (seg == 0) ? 32'hC000_0000 : (seg == 1) ? 32'hC100_0000 : 32'h4B00_0000;
        return {last, 2'(seg), base + 32'(idx)};
    endfunction

    task automatic push_run(input bit set4);
        int c0w;
        c0w = set4 ? 49 : 24;
        for (int i = 0; i < c0w + 16; i++) begin
            logic [34:0] e;
            if (i < c0w)           e = ent(0, i, 1'b0);
            else if (i < c0w + 8)  e = ent(1, i - c0w, 1'b0);
            else                   e = ent(2, i - c0w - 8, (i == c0w + 15));
            if (set4) q4.push_back(e);
            else      q1.push_back(e);
        end
    endtask

    task automatic pulse_start(input bit set4);
        @(posedge clk);
        #1;
        if (set4) start_4 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_4 = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 5000 && done_cnt1 < target; i++) @(negedge clk);
        chk("run_done_count", 64'(done_cnt1), 64'(target));
        chk("run_queue_empty", 64'(q1.size()), 64'd0);
    endtask

    task automatic wait_pops(input int target);
        for (int i = 0; i < 5000 && n_pop1 < target; i++) @(negedge clk);
        chk("reach_word", 64'(n_pop1 >= target), 64'd1);
    endtask

    task automatic chk_idle_outs(input string name);
        chk(name, {busy, done, dout_valid, dout, dout_seg, dout_last, rd_C0, rd_C1, rd_K,
                   C0_addr, C1_addr, K_addr}, 64'd0);
    endtask

    // ready pattern: 0 = always ready, 1 = random 50%, 2 = stalled
    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = 1'($urandom_range(0, 1));
                default: dout_ready = 1'b0;
            endcase
        end
    end

    // monitor: pops the scoreboard on every handshake, checks done timing and stalls
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                done_exp1   = 1'b0;
                done_exp4   = 1'b0;
                prev_stall1 = 1'b0;
            end else begin
                if (done) done_cnt1++;
                if (done_exp1) begin
                    chk("done_after_last", {done, busy}, 2'b10);
                    done_exp1 = 1'b0;
                end else if (done) begin
                    chk("spurious_done", done, 1'b0);
                end
                if (prev_stall1)
                    chk("stall_hold", {dout_valid, dout_last, dout_seg, dout}, {1'b1, prev_word1});
                if (rd_C0 || rd_C1 || rd_K) rd_cnt1++;
                if (dout_valid && dout_ready) begin
                    if (q1.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_word: got %0h, expected no word", dout);
                    end else begin
                        logic [34:0] e;
                        e = q1.pop_front();
                        chk($sformatf("word%0d", n_pop1), {dout_last, dout_seg, dout}, e);
                        n_pop1++;
                        if (e[34]) done_exp1 = 1'b1;
                    end
                end
                prev_stall1 = dout_valid && !dout_ready;
                prev_word1  = {dout_last, dout_seg, dout};

                if (done_4) done_cnt4++;
                if (done_exp4) begin
                    chk("done4_after_last", {done_4, busy_4}, 2'b10);
                    done_exp4 = 1'b0;
                end else if (done_4) begin
                    chk("spurious_done4", done_4, 1'b0);
                end
                if (rd_C0_4) last_c0_4 = C0_addr_4;
                if (rd_C1_4 && !seen_c1_4) begin
                    seen_c1_4      = 1'b1;
                    first_c1_4     = C1_addr_4;
                    c0_at_switch_4 = last_c0_4;
                end
                if (valid_4 && ready_4) begin
                    if (q4.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_word4: got %0h, expected no word", dout_4);
                    end else begin
                        logic [34:0] e;
                        e = q4.pop_front();
                        chk($sformatf("set4_word%0d", n_pop4), {last_4, seg_4, dout_4}, e);
                        n_pop4++;
                        if (e[34]) done_exp4 = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int base;
        rst = 1'b0;
        start = 1'b0;
        start_4 = 1'b0;
        ready_4 = 1'b1;
        #1;
        chk_idle_outs("reset_outputs");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // full stream with ready held high, first valid two cycles after start
        mode = 0;
        push_run(1'b0);
        pulse_start(1'b0);
        chk("busy_after_start", busy, 1'b1);
        @(negedge clk);
        chk("valid_start_plus0", dout_valid, 1'b0);
        @(negedge clk);
        chk("valid_start_plus1", dout_valid, 1'b0);
        @(negedge clk);
        chk("valid_start_plus2", dout_valid, 1'b1);
        wait_done(1);

        // random backpressure
        mode = 1;
        push_run(1'b0);
        pulse_start(1'b0);
        wait_done(2);

        // consumer stalled: two reads, head held, then resume
        mode = 2;
        push_run(1'b0);
        @(negedge clk);
        rd_cnt1 = 0;
        pulse_start(1'b0);
        repeat (20) @(negedge clk);
        chk("stall_read_count", 64'(rd_cnt1), 64'd2);
        chk("stall_head_word", {dout_valid, dout}, {1'b1, 32'hC000_0000});
        mode = 0;
        wait_done(3);

        // start while busy and start on the done pulse are both ignored
        mode = 1;
        push_run(1'b0);
        base = n_pop1;
        pulse_start(1'b0);
        wait_pops(base + 10);
        pulse_start(1'b0);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("start_on_done_ignored", {busy, dout_valid}, 2'b00);
        end
        chk("single_done", 64'(done_cnt1), 64'd4);
        chk("misuse_queue_empty", 64'(q1.size()), 64'd0);

        // asynchronous reset mid-stream, then a clean restart
        push_run(1'b0);
        base = n_pop1;
        pulse_start(1'b0);
        wait_pops(base + 30);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk_idle_outs("async_reset_outputs");
        q1.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_done_after_reset", 64'(done_cnt1), 64'd4);
        push_run(1'b0);
        pulse_start(1'b0);
        wait_done(5);

        // parameter set 4: 49 C0 words, 65 words total
        push_run(1'b1);
        pulse_start(1'b1);
        for (int i = 0; i < 5000 && done_cnt4 < 1; i++) @(negedge clk);
        chk("set4_done_count", 64'(done_cnt4), 64'd1);
        chk("set4_queue_empty", 64'(q4.size()), 64'd0);
        chk("set4_word_count", 64'(n_pop4), 64'd65);
        chk("set4_last_c0_addr", 64'(c0_at_switch_4), 64'd48);
        chk("set4_first_c1_addr", 64'(first_c1_4), 64'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
